// File: rtl/pc_pkg.sv
// Shared constants for the program-counter slice: address width, reset vector
// and the word increment used to form the sequential successor.
package pc_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam int unsigned PC_INCR  = 4;

  // Drop the byte-offset bits so the result is always a word address.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_adder.sv
// WIDTH-bit word incrementer producing the sequential successor of a PC.
module pc_adder
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = ADDR_W
) (
  input  logic [WIDTH-1:0] i_a,
  output logic [WIDTH-1:0] o_sum
);

  // Carry out of the top bit is intentionally lost: the PC wraps modulo 2^WIDTH.
  assign o_sum = i_a + WIDTH'(PC_INCR);

endmodule

// File: rtl/pc.sv
// MIPS program counter: word-aligned load with stall, sticky misalignment flag,
// and combinational PC+4 for the next-PC mux.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH       = ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             PC_WRITE,
  input  logic [WIDTH-1:0] PC_IN,
  output logic [WIDTH-1:0] PC_OUT,
  output logic [WIDTH-1:0] PC_PLUS4,
  output logic             ALIGN_ERR
);

  logic [WIDTH-1:0] r_pc;
  logic             r_align_err;
  logic [WIDTH-1:0] w_pc_aligned;
  logic             w_misaligned;

  assign w_pc_aligned = {PC_IN[WIDTH-1:2], 2'b00};
  assign w_misaligned = |PC_IN[1:0];

  // Reset vector is masked too, so PC_OUT[1:0] stays zero even if misconfigured.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pc        <= {RESET_VALUE[WIDTH-1:2], 2'b00};
      r_align_err <= 1'b0;
    end else if (PC_WRITE) begin
      r_pc <= w_pc_aligned;
      if (w_misaligned) begin
        r_align_err <= 1'b1;
      end
    end
  end

  pc_adder #(
    .WIDTH(WIDTH)
  ) u_pc_adder (
    .i_a  (r_pc),
    .o_sum(PC_PLUS4)
  );

  assign PC_OUT    = r_pc;
  assign ALIGN_ERR = r_align_err;

endmodule

// File: tb/tb_pc.sv
// Self-checking bench for pc: directed test-plan steps followed by random
// loads/stalls/resets compared against an arithmetic reference model.
module tb_pc;

  logic        CLK;
  logic        RST;
  logic        PC_WRITE;
  logic [31:0] PC_IN;
  logic [31:0] PC_OUT;
  logic [31:0] PC_PLUS4;
  logic        ALIGN_ERR;

  int unsigned total;
  int unsigned bad;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_err;

  pc #(
    .WIDTH      (32),
    .RESET_VALUE(32'h0000_0000)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PC_WRITE (PC_WRITE),
    .PC_IN    (PC_IN),
    .PC_OUT   (PC_OUT),
    .PC_PLUS4 (PC_PLUS4),
    .ALIGN_ERR(ALIGN_ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_plus4(input logic [31:0] p);
    longint unsigned s;
    s = (longint'(p) + 4) % 64'h1_0000_0000;
    return s[31:0];
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".pc"}, PC_OUT, m_pc);
    chk({tag, ".plus4"}, PC_PLUS4, model_plus4(m_pc));
    chk({tag, ".err"}, {31'd0, ALIGN_ERR}, {31'd0, m_err});
  endtask

  // Called just after an edge; drives inputs, waits for the next edge, checks.
  task automatic step(input logic we, input logic [31:0] din, input string tag);
    PC_WRITE = we;
    PC_IN    = din;
    @(posedge CLK);
    if (!RST && we) begin
      m_pc = (din / 4) * 4;
      if (din % 4 != 0) m_err = 1'b1;
    end
    #1;
    chk_all(tag);
  endtask

  // Mid-cycle reset pulse, checked before any clock edge.
  task automatic rst_pulse(input string tag);
    RST = 1'b1;
    #1;
    m_pc  = 32'd0;
    m_err = 1'b0;
    chk_all(tag);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    RST      = 1'b1;
    PC_WRITE = 1'b1;
    PC_IN    = 32'd20;
    m_pc     = 32'd0;
    m_err    = 1'b0;
    #2;
    chk("reset.pc", PC_OUT, 32'd0);
    chk("reset.plus4", PC_PLUS4, 32'd4);
    chk("reset.err", {31'd0, ALIGN_ERR}, 32'd0);

    // Load on an edge while RST is high is discarded
    @(posedge CLK);
    #1;
    chk("rst_edge.pc", PC_OUT, 32'd0);
    RST = 1'b0;

    step(1'b1, 32'd0, "seq0");
    step(1'b1, 32'd20, "seq20");
    chk("seq20.const", PC_PLUS4, 32'd24);
    step(1'b1, 32'd1024, "seq1024");
    chk("seq1024.const", PC_PLUS4, 32'd1028);
    step(1'b1, 32'd256, "seq256");
    chk("seq256.const", PC_PLUS4, 32'd260);

    step(1'b1, 32'd1024, "stall.pre");
    for (int i = 0; i < 3; i++) step(1'b0, 32'd256, "stall");
    chk("stall.const", PC_OUT, 32'd1024);

    step(1'b0, 32'd23, "stall_misaligned");
    step(1'b1, 32'd22, "mis22");
    chk("mis22.pc", PC_OUT, 32'd20);
    chk("mis22.err", {31'd0, ALIGN_ERR}, 32'd1);
    step(1'b1, 32'd256, "mis.sticky");
    chk("sticky.err", {31'd0, ALIGN_ERR}, 32'd1);
    rst_pulse("mis.rst");

    step(1'b1, 32'hFFFF_FFFC, "wrap");
    chk("wrap.const", PC_PLUS4, 32'd0);

    step(1'b1, 32'd1024, "async.pre");
    rst_pulse("async");
    chk("async.const", PC_OUT, 32'd0);
    step(1'b1, 32'd20, "async.post");
    chk("async.post.const", PC_OUT, 32'd20);

    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [31:0] din;
      we  = ($urandom_range(0, 3) != 0);
      din = $urandom;
      if ($urandom_range(0, 3) != 0) din[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) din = 32'hFFFF_FFFC;
      if ($urandom_range(0, 24) == 0) rst_pulse("rand.rst");
      step(we, din, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
